// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the two-requester Avalon bus arbiter.
package mem_bus_arb_pkg;

  // Transfer sequencer states: idle/arbitrate, bus phase, response pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Requester identifiers; also the bit index in the request/grant vectors.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Instruction fetches always read a full word.
  localparam logic [3:0] FETCH_BE = 4'hF;

  // Write data is only meaningful on a data write; every other transfer
  // drives zero so the bus never carries stale store data.
  function automatic logic [31:0] sel_wdata(input logic        is_data,
                                            input logic        we,
                                            input logic [31:0] wdata);
    return (is_data && we) ? wdata : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: the requester not served last wins a tie.
module rr_arb2
  import mem_bus_arb_pkg::*;
(
  input  logic [1:0] i_req,   // bit REQ_FETCH / bit REQ_DATA
  input  logic       i_last,  // ID of the requester served most recently
  output logic [1:0] o_gnt    // one-hot grant, zero when nobody requests
);

  // Combinational grant selection from the request pair and last pointer.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last == REQ_DATA) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch port and a data port onto a single Avalon-MM master.
// One transfer at a time: IDLE (grant) -> BUS (until waitrequest low) ->
// RESP (one-cycle ack) -> IDLE. All bus and requester outputs are registered.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  // Avalon master
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  arb_state_t  r_state;
  logic        r_last;
  logic        r_gnt;
  logic [31:0] r_address;
  logic [31:0] r_writedata;
  logic        r_read;
  logic        r_write;
  logic [3:0]  r_byteenable;
  logic        r_if_ack;
  logic        r_d_ack;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_any_gnt;
  logic        w_win_data;
  logic [31:0] w_win_addr;
  logic [3:0]  w_win_be;
  logic        w_win_read;
  logic        w_win_write;

  assign w_req = {d_req, if_req};

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_any_gnt   = |w_gnt;
  assign w_win_data  = w_gnt[REQ_DATA];
  assign w_win_addr  = w_win_data ? d_addr : if_addr;
  assign w_win_be    = w_win_data ? d_be : FETCH_BE;
  assign w_win_read  = w_win_data ? ~d_we : 1'b1;
  assign w_win_write = w_win_data & d_we;

  // Transfer sequencer: grant, hold the bus through stalls, pulse the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last       <= REQ_FETCH;
      r_gnt        <= REQ_FETCH;
      r_address    <= 32'h0000_0000;
      r_writedata  <= 32'h0000_0000;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_byteenable <= 4'h0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_if_rdata   <= 32'h0000_0000;
      r_d_rdata    <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          if (w_any_gnt) begin
            // Capture the winner's transfer so the bus holds still
            // regardless of what the requester does afterwards.
            r_gnt        <= w_win_data;
            r_last       <= w_win_data;
            r_address    <= w_win_addr;
            r_writedata  <= sel_wdata(w_win_data, d_we, d_wdata);
            r_byteenable <= w_win_be;
            r_read       <= w_win_read;
            r_write      <= w_win_write;
            r_state      <= ST_BUS;
          end else begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (!waitrequest) begin
            if (r_read) begin
              if (r_gnt == REQ_DATA) begin
                r_d_rdata <= readdata;
              end else begin
                r_if_rdata <= readdata;
              end
            end
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_if_ack <= (r_gnt == REQ_FETCH);
            r_d_ack  <= (r_gnt == REQ_DATA);
            r_state  <= ST_RESP;
          end else begin
            r_state <= ST_BUS;
          end
        end
        ST_RESP: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_read   <= 1'b0;
          r_write  <= 1'b0;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign writedata  = r_writedata;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_byteenable;
  assign if_ack     = r_if_ack;
  assign d_ack      = r_d_ack;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. The bench plays both
// requesters and the Avalon slave; outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .address     (address),
    .writedata   (writedata),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({read, write, if_ack, d_ack} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b want=0000", {read, write, if_ack, d_ack});
    end
    checks++;
    if (address !== 32'h0 || writedata !== 32'h0 || byteenable !== 4'h0) begin
      failures++; $display("FAIL reset_bus got addr=%h wd=%h be=%h want 0", address, writedata, byteenable);
    end
    checks++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got if=%h d=%h want 0", if_rdata, d_rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (read !== 1'b0 || write !== 1'b0) begin
        failures++; $display("FAIL idle_no_req got rd=%b wr=%b want 0 0", read, write);
      end
    end
  endtask

  task automatic test_fetch();
    waitrequest = 1'b0;
    readdata    = 32'h8C01_0064;
    if_addr     = 32'hBFC0_0000;
    if_req      = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC0_0000 || byteenable !== 4'hF) begin
      failures++; $display("FAIL fetch_bus got rd=%b wr=%b addr=%h be=%h want 1 0 bfc00000 f", read, write, address, byteenable);
    end
    checks++;
    if (if_ack !== 1'b0) begin
      failures++; $display("FAIL fetch_early_ack got=%b want=0", if_ack);
    end
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h8C01_0064) begin
      failures++; $display("FAIL fetch_ack got ack=%b dack=%b rdata=%h want 1 0 8c010064", if_ack, d_ack, if_rdata);
    end
    checks++;
    if (read !== 1'b0) begin
      failures++; $display("FAIL fetch_strobe_drop got=%b want=0", read);
    end
    if_req   = 1'b0;
    readdata = 32'h0;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h8C01_0064) begin
      failures++; $display("FAIL fetch_ack_once got ack=%b rdata=%h want 0 8c010064", if_ack, if_rdata);
    end
  endtask

  task automatic test_write_stall();
    readdata    = 32'hDEAD_BEEF;
    waitrequest = 1'b1;
    d_we        = 1'b1;
    d_addr      = 32'd200;
    d_wdata     = 32'd404;
    d_be        = 4'hF;
    d_req       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (write !== 1'b1 || read !== 1'b0 || address !== 32'd200 || writedata !== 32'd404 || byteenable !== 4'hF || d_ack !== 1'b0) begin
        failures++; $display("FAIL wr_stall_%0d got wr=%b rd=%b addr=%0d wd=%0d be=%h ack=%b want 1 0 200 404 f 0",
                             i, write, read, address, writedata, byteenable, d_ack);
      end
      if (i == 3) waitrequest = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || if_ack !== 1'b0 || write !== 1'b0 || d_rdata !== 32'h0) begin
      failures++; $display("FAIL wr_ack got dack=%b iack=%b wr=%b drdata=%h want 1 0 0 0", d_ack, if_ack, write, d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0) begin
      failures++; $display("FAIL wr_ack_once got=%b want=0", d_ack);
    end
  endtask

  task automatic test_data_read();
    waitrequest = 1'b0;
    readdata    = 32'h0BAD_F00D;
    d_we        = 1'b0;
    d_addr      = 32'h0000_1003;
    d_wdata     = 32'hFFFF_FFFF;
    d_be        = 4'b1100;
    d_req       = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || address !== 32'h0000_1003 || byteenable !== 4'b1100 || writedata !== 32'h0) begin
      failures++; $display("FAIL drd_bus got rd=%b wr=%b addr=%h be=%b wd=%h want 1 0 00001003 1100 0",
                           read, write, address, byteenable, writedata);
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h0BAD_F00D || if_rdata !== 32'h8C01_0064) begin
      failures++; $display("FAIL drd_ack got ack=%b d=%h if=%h want 1 0badf00d 8c010064", d_ack, d_rdata, if_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_store();
    readdata    = 32'h5555_5555;
    waitrequest = 1'b1;
    d_we        = 1'b1;
    d_addr      = 32'd206;
    d_wdata     = 32'h0000_00AB;
    d_be        = 4'b0001;
    d_req       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (byteenable !== 4'b0001 || read !== 1'b0 || write !== 1'b1 || address !== 32'd206 || writedata !== 32'h0000_00AB) begin
        failures++; $display("FAIL sb_bus_%0d got be=%b rd=%b wr=%b addr=%0d wd=%h want 0001 0 1 206 000000ab",
                             i, byteenable, read, write, address, writedata);
      end
      if (i == 1) waitrequest = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || read !== 1'b0 || d_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL sb_ack got ack=%b rd=%b drdata=%h want 1 0 0badf00d", d_ack, read, d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int n_dack;
    int n_iack;
    n_dack = 0;
    n_iack = 0;
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    waitrequest = 1'b0;
    readdata    = 32'h1111_2222;
    if_addr     = 32'h0000_0100;
    d_addr      = 32'h0000_2000;
    d_we        = 1'b0;
    d_be        = 4'hF;
    if_req      = 1'b1;
    d_req       = 1'b1;
    // Period of 6: data BUS, d_ack, IDLE, fetch BUS, if_ack, IDLE.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (d_ack === 1'b1) n_dack++;
      if (if_ack === 1'b1) n_iack++;
      checks++;
      if (if_ack !== (i % 6 == 4) || d_ack !== (i % 6 == 1)) begin
        failures++; $display("FAIL rr_ack_%0d got iack=%b dack=%b want %b %b", i, if_ack, d_ack, (i % 6 == 4), (i % 6 == 1));
      end
      if (i % 6 == 0) begin
        checks++;
        if (read !== 1'b1 || address !== 32'h0000_2000) begin
          failures++; $display("FAIL rr_data_grant_%0d got rd=%b addr=%h want 1 00002000", i, read, address);
        end
      end
      if (i % 6 == 3) begin
        checks++;
        if (read !== 1'b1 || address !== 32'h0000_0100) begin
          failures++; $display("FAIL rr_fetch_grant_%0d got rd=%b addr=%h want 1 00000100", i, read, address);
        end
      end
      if (i == 11) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    checks++;
    if (n_dack != 2 || n_iack != 2) begin
      failures++; $display("FAIL rr_ack_count got d=%0d i=%0d want 2 2", n_dack, n_iack);
    end
    @(negedge clk);
    checks++;
    if (read !== 1'b0 || write !== 1'b0) begin
      failures++; $display("FAIL rr_idle_after got rd=%b wr=%b want 0 0", read, write);
    end
  endtask

  task automatic test_reset_mid_bus();
    waitrequest = 1'b1;
    if_addr     = 32'h0000_0040;
    if_req      = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got rd=%b want 1", read);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got rd=%b wr=%b iack=%b dack=%b want 0 0 0 0", read, write, if_ack, d_ack);
    end
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || read !== 1'b0) begin
      failures++; $display("FAIL rst_mid_hold got iack=%b rd=%b want 0 0", if_ack, read);
    end
    reset       = 1'b0;
    waitrequest = 1'b0;
    readdata    = 32'hCAFE_0001;
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || address !== 32'h0000_0040) begin
      failures++; $display("FAIL rst_mid_retry got rd=%b addr=%h want 1 00000040", read, address);
    end
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'hCAFE_0001) begin
      failures++; $display("FAIL rst_mid_ack got ack=%b rdata=%h want 1 cafe0001", if_ack, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_ack;
    n_ack       = 0;
    waitrequest = 1'b0;
    readdata    = 32'h7777_0000;
    if_addr     = 32'h0000_0080;
    if_req      = 1'b1;
    // Period of 3: BUS, RESP (ack), IDLE (bus idle, new grant).
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (if_ack === 1'b1) n_ack++;
      checks++;
      if (read !== (i % 3 == 0) || if_ack !== (i % 3 == 1) || d_ack !== 1'b0) begin
        failures++; $display("FAIL b2b_%0d got rd=%b iack=%b dack=%b want %b %b 0", i, read, if_ack, d_ack, (i % 3 == 0), (i % 3 == 1));
      end
      if (i == 8) if_req = 1'b0;
    end
    checks++;
    if (n_ack != 3 || if_rdata !== 32'h7777_0000) begin
      failures++; $display("FAIL b2b_count got acks=%0d rdata=%h want 3 77770000", n_ack, if_rdata);
    end
  endtask

  initial begin
    reset       = 1'b1;
    if_req      = 1'b0;
    if_addr     = 32'h0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_addr      = 32'h0;
    d_wdata     = 32'h0;
    d_be        = 4'h0;
    waitrequest = 1'b0;
    readdata    = 32'h0;
    test_reset();
    test_fetch();
    test_write_stall();
    test_data_read();
    test_byte_store();
    test_simultaneous();
    test_reset_mid_bus();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
